conv_loop_ctrl: RTL and testbench

- Loop sequencer for the convolution datapath: once the top-level mode FSM enters a conv layer, it walks output channel, output row, output column and input channel.
- Per datapath cycle it issues index/valid strobes plus accumulator clear/write-back flags.
- After the pipeline drains it raises the layer-complete pulse (conv1_done / conv_done) that the top-level FSM consumes.
- Sits between the mode FSM and the conv MAC/SRAM address logic.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_idx_counter.sv | 26 ++
 rtl/conv_loop_ctrl.sv | 173 +++++++++++++++++
 tb/tb_conv_loop_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution loop sequencer: top-FSM mode
// encodings, default layer geometry and the controller state enum.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_CONV1 = 2'd1,
        MODE_CONV2 = 2'd2,
        MODE_DONE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } ctrl_state_e;

    localparam int C1_OCH_DEF   = 6;
    localparam int C1_ICH_DEF   = 1;
    localparam int C1_OUT_DEF   = 24;
    localparam int C2_OCH_DEF   = 16;
    localparam int C2_ICH_DEF   = 6;
    localparam int C2_OUT_DEF   = 8;
    localparam int PIPE_LAT_DEF = 3;
    localparam int IDX_W_DEF    = 5;

endpackage

// File: rtl/conv_idx_counter.sv
// Wrapping index counter. wrap is combinational (en & idx==bound-1) so a
// chain of these counters carries within the same cycle.
module conv_idx_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] bound,
    output logic [W-1:0] idx,
    output logic         wrap
);

    assign wrap = en & (idx == (bound - W'(1)));

    // Advance on enable, returning to zero after the last value.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= wrap ? '0 : idx + W'(1);
        end
    end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Convolution loop sequencer. Walks och > row > col > ich (ich innermost)
// for the layer armed by the mode FSM, drains the datapath pipeline and
// pulses conv1_done / conv_done.
// Optional: define CONV_PERF_CNT_EN to add the stall_cyc performance counter.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_IDLE  | waiting for a fresh mode transition to CONV1/CONV2
//   ST_RUN   | issuing one index tuple per non-stalled cycle
//   ST_DRAIN | waiting PIPE_LAT cycles for the last write-back
//   ST_FIN   | one-cycle done pulse, then back to idle
module conv_loop_ctrl
    import conv_pkg::*;
#(
    parameter int C1_OCH   = C1_OCH_DEF,
    parameter int C1_ICH   = C1_ICH_DEF,
    parameter int C1_OUT   = C1_OUT_DEF,
    parameter int C2_OCH   = C2_OCH_DEF,
    parameter int C2_ICH   = C2_ICH_DEF,
    parameter int C2_OUT   = C2_OUT_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [1:0]       mode,
    input  logic             stall,
    output logic             issue_vld,
    output logic [IDX_W-1:0] och,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic [IDX_W-1:0] ich,
    output logic             acc_clr,
    output logic             acc_wb,
    output logic             busy,
    output logic             conv1_done,
    output logic             conv_done
`ifdef CONV_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cyc
`endif
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    ctrl_state_e      state;
    logic [1:0]       mode_q;
    logic             start_blk;
    logic             layer2;
    logic [IDX_W-1:0] och_bnd;
    logic [IDX_W-1:0] out_bnd;
    logic [IDX_W-1:0] ich_bnd;
    logic [DRN_W-1:0] drain_cnt;

    logic start;
    logic abort;
    logic issue;
    logic wrap_ich;
    logic wrap_col;
    logic wrap_row;
    logic wrap_och;

    // A start needs a genuine edge on mode. start_blk masks the first cycle
    // after reset, where mode_q is forced to 0 but mode may still be held at
    // a conv layer; without it a reset would look like a fresh transition.
    assign start = (state == ST_IDLE) && !start_blk &&
                   ((mode == MODE_CONV1) || (mode == MODE_CONV2)) &&
                   (mode != mode_q);
    assign abort = (mode == MODE_IDLE) && ((state == ST_RUN) || (state == ST_DRAIN));

    // issue_vld follows stall combinationally so a stalled cycle never issues.
    assign issue     = (state == ST_RUN) && !stall;
    assign issue_vld = issue;
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign acc_clr   = issue && (ich == '0);
    assign acc_wb    = issue && (ich == (ich_bnd - IDX_W'(1)));

    conv_idx_counter #(.W(IDX_W)) u_ich (
        .clk(clk), .srst(srst), .clr(start | abort), .en(issue),
        .bound(ich_bnd), .idx(ich), .wrap(wrap_ich)
    );
    conv_idx_counter #(.W(IDX_W)) u_col (
        .clk(clk), .srst(srst), .clr(start | abort), .en(wrap_ich),
        .bound(out_bnd), .idx(col), .wrap(wrap_col)
    );
    conv_idx_counter #(.W(IDX_W)) u_row (
        .clk(clk), .srst(srst), .clr(start | abort), .en(wrap_col),
        .bound(out_bnd), .idx(row), .wrap(wrap_row)
    );
    conv_idx_counter #(.W(IDX_W)) u_och (
        .clk(clk), .srst(srst), .clr(start | abort), .en(wrap_row),
        .bound(och_bnd), .idx(och), .wrap(wrap_och)
    );

    // Control FSM: arming, run/drain sequencing and registered done pulses.
    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= ST_IDLE;
            mode_q     <= 2'd0;
            start_blk  <= 1'b1;
            layer2     <= 1'b0;
            och_bnd    <= '0;
            out_bnd    <= '0;
            ich_bnd    <= '0;
            drain_cnt  <= '0;
            conv1_done <= 1'b0;
            conv_done  <= 1'b0;
        end else begin
            mode_q     <= mode;
            start_blk  <= 1'b0;
            conv1_done <= 1'b0;
            conv_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        layer2 <= (mode == MODE_CONV2);
                        if (mode == MODE_CONV2) begin
                            och_bnd <= IDX_W'(C2_OCH);
                            out_bnd <= IDX_W'(C2_OUT);
                            ich_bnd <= IDX_W'(C2_ICH);
                        end else begin
                            och_bnd <= IDX_W'(C1_OCH);
                            out_bnd <= IDX_W'(C1_OUT);
                            ich_bnd <= IDX_W'(C1_ICH);
                        end
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (wrap_och) begin
                        drain_cnt <= DRN_W'(PIPE_LAT - 1);
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leaving on the count-to-1 step places the done pulse
                    // exactly PIPE_LAT cycles after the last issue.
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (!stall) begin
                        if (drain_cnt <= DRN_W'(1)) begin
                            conv1_done <= !layer2;
                            conv_done  <= layer2;
                            state      <= ST_FIN;
                        end else begin
                            drain_cnt <= drain_cnt - DRN_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_PERF_CNT_EN
    // Saturating count of busy cycles lost to backpressure, per layer run.
    always_ff @(posedge clk) begin
        if (srst || start) begin
            stall_cyc <= 16'd0;
        end else if (busy && stall && (stall_cyc != 16'hFFFF)) begin
            stall_cyc <= stall_cyc + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Scoreboard bench for conv_loop_ctrl: stimulus pushes the expected issue
// sequence and done events; a negedge monitor pops and compares.
module tb_conv_loop_ctrl;

    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] och;
        logic [W-1:0] row;
        logic [W-1:0] col;
        logic [W-1:0] ich;
        logic         clr;
        logic         wb;
    } iss_t;

    typedef struct packed {
        logic        l2;
        logic [15:0] lat;
    } done_t;

    logic         clk = 1'b0;
    logic         srst;
    logic [1:0]   mode;
    logic         stall;
    logic         issue_vld;
    logic [W-1:0] och, row, col, ich;
    logic         acc_clr, acc_wb, busy, conv1_done, conv_done;
`ifdef CONV_PERF_CNT_EN
    logic [15:0]  stall_cyc;
`endif

    conv_loop_ctrl dut (
        .clk(clk), .srst(srst), .mode(mode), .stall(stall),
        .issue_vld(issue_vld), .och(och), .row(row), .col(col), .ich(ich),
        .acc_clr(acc_clr), .acc_wb(acc_wb), .busy(busy),
        .conv1_done(conv1_done), .conv_done(conv_done)
`ifdef CONV_PERF_CNT_EN
        , .stall_cyc(stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    iss_t  exp_q[$];
    done_t done_q[$];
    int checks = 0;
    int failures = 0;
    int n_issue = 0, n_clr = 0, n_wb = 0, n_c1 = 0, n_c2 = 0;
    int last_iss = 0, done_cyc = 0;
    bit mon_en = 1'b0;
    int t0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_issue = 0; n_clr = 0; n_wb = 0; n_c1 = 0; n_c2 = 0;
    endtask

    task automatic wait_issues(input int target, input int budget, input string nm);
        int k = 0;
        while (n_issue < target && k < budget) begin
            @(posedge clk); #1; k++;
        end
        if (n_issue < target) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", nm, n_issue, target);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int k = 0;
        while ((n_c1 + n_c2) < target && k < budget) begin
            @(posedge clk); #1; k++;
        end
        if ((n_c1 + n_c2) < target) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", nm, n_c1 + n_c2, target);
        end
    endtask

    // Reference loop nest: och outermost, ich innermost.
    task automatic push_layer(input bit l2);
        int no = l2 ? 16 : 6;
        int ni = l2 ? 6 : 1;
        int nw = l2 ? 8 : 24;
        iss_t e;
        for (int o = 0; o < no; o++)
            for (int r = 0; r < nw; r++)
                for (int c = 0; c < nw; c++)
                    for (int i = 0; i < ni; i++) begin
                        e.och = W'(o); e.row = W'(r); e.col = W'(c); e.ich = W'(i);
                        e.clr = (i == 0); e.wb = (i == ni - 1);
                        exp_q.push_back(e);
                    end
    endtask

    task automatic push_done(input bit l2, input int lat);
        done_t d;
        d.l2 = l2; d.lat = 16'(lat);
        done_q.push_back(d);
    endtask

    // Monitor: pops expected issues / done events whenever the DUT presents one.
    initial begin
        iss_t got, e;
        done_t d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (issue_vld === 1'b1) begin
                    n_issue++;
                    if (acc_clr) n_clr++;
                    if (acc_wb) n_wb++;
                    last_iss = cyc;
                    got = {och, row, col, ich, acc_clr, acc_wb};
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL issue_unexpected actual och=%0d row=%0d col=%0d ich=%0d required=none",
                                 och, row, col, ich);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            failures++;
                            $display("FAIL issue_seq n=%0d actual och=%0d row=%0d col=%0d ich=%0d clr=%0b wb=%0b required och=%0d row=%0d col=%0d ich=%0d clr=%0b wb=%0b",
                                     n_issue, och, row, col, ich, acc_clr, acc_wb,
                                     e.och, e.row, e.col, e.ich, e.clr, e.wb);
                        end
                    end
                end
                if (conv1_done === 1'b1 || conv_done === 1'b1) begin
                    if (conv1_done) n_c1++;
                    if (conv_done) n_c2++;
                    done_cyc = cyc;
                    checks++;
                    if (done_q.size() == 0) begin
                        failures++;
                        $display("FAIL done_unexpected actual c1=%0b c2=%0b required=none", conv1_done, conv_done);
                    end else begin
                        d = done_q.pop_front();
                        if ({conv1_done, conv_done} !== {!d.l2, d.l2} || (cyc - last_iss) != int'(d.lat)) begin
                            failures++;
                            $display("FAIL done_event actual c1=%0b c2=%0b lat=%0d required c1=%0b c2=%0b lat=%0d",
                                     conv1_done, conv_done, cyc - last_iss, !d.l2, d.l2, d.lat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        srst = 1'b1; mode = 2'd0; stall = 1'b0;
        step(3);
        srst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {issue_vld, busy, conv1_done, conv_done, acc_clr, acc_wb, och, row, col, ich}, 0);
`ifdef CONV_PERF_CNT_EN
        chk("reset_stall_cyc", stall_cyc, 0);
`endif

        // Reset mid-run, then mode held at CONV1 must not restart.
        step(1);
        clear_counts(); push_layer(0); mode = 2'd1;
        wait_issues(20, 100, "rst_run");
        srst = 1'b1; step(1); srst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {issue_vld, busy, conv1_done, conv_done, acc_clr, acc_wb, och, row, col, ich}, 0);
        chk("rst_mid_issued", n_issue, 21);
        chk("rst_mid_queue", exp_q.size(), 3456 - 21);
        exp_q.delete();
        step(50);
        chk("rst_mid_no_restart", n_issue, 21);
        chk("rst_mid_no_done", n_c1 + n_c2, 0);

        // Layer 1 normal.
        mode = 2'd0; step(2);
        clear_counts(); push_layer(0); push_done(0, 3);
        mode = 2'd1; t0 = cyc;
        wait_done(1, 4000, "l1_done");
        step(2);
        chk("l1_done_cycle", done_cyc - t0, 3459);
        chk("l1_issues", n_issue, 3456);
        chk("l1_acc_clr", n_clr, 3456);
        chk("l1_acc_wb", n_wb, 3456);
        chk("l1_conv1_done", n_c1, 1);
        chk("l1_no_conv_done", n_c2, 0);
        chk("l1_queue_empty", exp_q.size(), 0);

        // Layer 2 normal, entered by the 1->2 transition.
        clear_counts(); push_layer(1); push_done(1, 3);
        mode = 2'd2; t0 = cyc;
        wait_done(1, 7000, "l2_done");
        step(2);
        chk("l2_done_cycle", done_cyc - t0, 6147);
        chk("l2_issues", n_issue, 6144);
        chk("l2_acc_clr", n_clr, 1024);
        chk("l2_acc_wb", n_wb, 1024);
        chk("l2_conv_done", n_c2, 1);
        chk("l2_no_conv1_done", n_c1, 0);

        // Layer 2 with 5 stall cycles at issue 100 and 2 during drain.
        mode = 2'd0; step(2);
        clear_counts(); push_layer(1); push_done(1, 5);
        mode = 2'd2; t0 = cyc;
        wait_issues(100, 200, "stall_run");
        stall = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_frozen", {issue_vld, och, row, col, ich}, {1'b0, 5'd0, 5'd2, 5'd0, 5'd4});
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_issues(6144, 7000, "stall_last");
        stall = 1'b1; step(2); stall = 1'b0;
        wait_done(1, 50, "stall_done");
        step(3);
        chk("stall_done_cycle", done_cyc - t0, 6154);
        chk("stall_issues", n_issue, 6144);
        chk("stall_conv_done", n_c2, 1);
`ifdef CONV_PERF_CNT_EN
        chk("stall_cyc", stall_cyc, 7);
`endif

        // mode held at CONV2 after completion must not retrigger.
        clear_counts();
        step(10000);
        chk("noretrig_issues", n_issue, 0);
        chk("noretrig_done", n_c1 + n_c2, 0);
        chk("noretrig_busy", busy, 0);

        // Abort at issue 500, then restart from zero.
        mode = 2'd0; step(2);
        clear_counts(); push_layer(1);
        mode = 2'd2;
        wait_issues(500, 600, "abort_run");
        mode = 2'd0; step(1);
        @(negedge clk);
        chk("abort_state", {busy, issue_vld, och, row, col, ich}, 0);
        chk("abort_issued", n_issue, 501);
        chk("abort_queue", exp_q.size(), 6144 - 501);
        exp_q.delete();
        step(5);
        chk("abort_no_done", n_c1 + n_c2, 0);
        clear_counts(); push_layer(1); push_done(1, 3);
        mode = 2'd2; t0 = cyc;
        wait_done(1, 7000, "restart_done");
        step(2);
        chk("restart_done_cycle", done_cyc - t0, 6147);
        chk("restart_issues", n_issue, 6144);
        chk("restart_conv_done", n_c2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
